world_tile_writer: RTL and testbench

- Write-side engine for the 40x30 world tile map, i.e. the 1200-cell, 5-bit sprite-code map.
- Gameplay logic issues tile edits through a valid/ready command port: single-cell SET (brick broken, coin taken) or run-length FILL (level clear/reload).
- Commands are buffered in a small FIFO and committed to the world map RAM write port only while vertical blanking is active.
- This keeps the per-pixel collision/render readers from ever seeing a half-updated frame.

---
 rtl/world_tile_writer.sv | 93 +++++++++
 tb/tb_world_tile_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/world_tile_writer.sv
// world_tile_writer: buffers SET/FILL tile edits in a small FIFO and commits them to the world map RAM only during vertical blank.
module world_tile_writer #(
  parameter int NUM_CELLS  = 1200,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_vblank,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [2:0]        o_fifo_count,
  output logic              o_busy,
  output logic              o_done_pulse,
  output logic              o_err_pulse
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] NC = (ADDR_W + 1)'(NUM_CELLS);
  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE} state_t;
  state_t            r_state, w_next;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [2:0]        r_count;
  logic [ADDR_W-1:0] r_cur_addr, r_cur_rem;
  logic [DATA_W-1:0] r_cur_data;
  logic              r_last;
  logic [ADDR_W:0]   w_end;
  logic              w_legal, w_fire, w_push, w_pop, w_write;
  assign w_end   = {1'b0, i_cmd_addr} + {1'b0, i_cmd_len};
  assign w_legal = i_cmd_op ? (i_cmd_len != '0 && w_end <= NC) : ({1'b0, i_cmd_addr} < NC);
  assign w_fire  = i_cmd_valid & o_cmd_ready;
  assign w_push  = w_fire & w_legal;
  assign w_pop   = (r_state == IDLE) && (r_count != '0);
  // A pending command writes on any edge where vblank is high, so WAIT_BLANK commits directly.
  assign w_write = (r_state != IDLE) && i_vblank;
  assign o_cmd_ready  = r_count != 3'(FIFO_DEPTH);
  assign o_fifo_count = r_count;
  assign o_busy       = (r_count != '0) || (r_state != IDLE);
  always_comb begin
    w_next = r_state == IDLE ? (r_count != '0 ? WAIT_BLANK : IDLE) :
             !i_vblank ? WAIT_BLANK :
             r_cur_rem == ADDR_W'(1) ? IDLE : WRITE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {i_cmd_addr, i_cmd_op ? i_cmd_len : ADDR_W'(1), i_cmd_data};
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_cur_addr   <= '0;
      r_cur_rem    <= '0;
      r_cur_data   <= '0;
      r_last       <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_done_pulse <= 1'b0;
      o_err_pulse  <= 1'b0;
    end else begin
      o_err_pulse  <= w_fire & ~w_legal;
      o_wr_en      <= w_write;
      r_last       <= w_write && r_cur_rem == ADDR_W'(1);
      o_done_pulse <= r_last;
      r_count      <= r_count + 3'(w_push) - 3'(w_pop);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        {r_cur_addr, r_cur_rem, r_cur_data} <= r_mem[r_rptr];
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_write) begin
        o_wr_addr  <= r_cur_addr;
        o_wr_data  <= r_cur_data;
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_cur_rem  <= r_cur_rem - ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_world_tile_writer.sv
// tb_world_tile_writer: directed stimulus with a write scoreboard for world_tile_writer.
module tb_world_tile_writer;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, cmd_op = 0, vblank = 0;
  logic [10:0] cmd_addr = 0, cmd_len = 0;
  logic [4:0]  cmd_data = 0;
  logic        cmd_ready, wr_en, busy, done_pulse, err_pulse;
  logic [10:0] wr_addr;
  logic [4:0]  wr_data;
  logic [2:0]  fifo_count;
  int checks = 0, errors = 0, n_wr = 0, n_done = 0, n_err = 0;
  logic [15:0] exp_q[$];

  world_tile_writer dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_data(cmd_data),
    .i_vblank(vblank), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_fifo_count(fifo_count), .o_busy(busy), .o_done_pulse(done_pulse), .o_err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [15:0] e;
    if (done_pulse === 1'b1) n_done++;
    if (err_pulse === 1'b1) n_err++;
    if (wr_en === 1'b1) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data %0d, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_scoreboard: got addr %0d data %0d, expected addr %0d data %0d",
                   wr_addr, wr_data, e[15:5], e[4:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input int a, input int n, input int d);
    for (int i = 0; i < n; i++) exp_q.push_back({11'(a + i), 5'(d)});
  endtask

  task automatic send(input logic op, input int a, input int l, input int d);
    int k = 0;
    cmd_op = op; cmd_addr = 11'(a); cmd_len = 11'(l); cmd_data = 5'(d);
    cmd_valid = 1;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    chk("send_ready", int'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string name, input int max);
    int k = 0;
    while (done_pulse !== 1'b1 && k < max) begin tick(); k++; end
    chk(name, int'(done_pulse), 1);
  endtask

  initial begin
    int w0, d0, e0, c, g, k, b;
    // reset held with a legal command offered
    cmd_valid = 1; cmd_op = 0; cmd_addr = 5; cmd_data = 1;
    repeat (3) begin
      tick();
      chk("rst_outputs", int'({wr_en, wr_addr, wr_data, fifo_count, busy, done_pulse, err_pulse}), 0);
    end
    cmd_valid = 0;
    rst_n = 1;
    tick();
    chk("rel_ready", int'(cmd_ready), 1);
    chk("rel_count", int'(fifo_count), 0);
    chk("rel_busy", int'(busy), 0);

    // single SET with vblank open: latency and done
    vblank = 1;
    expect_run(41, 1, 5);
    send(0, 41, 0, 5);
    tick();
    chk("set_e1_wr", int'(wr_en), 0);
    chk("set_e1_busy", int'(busy), 1);
    tick();
    chk("set_e2_wr", int'(wr_en), 1);
    chk("set_e2_addr", int'(wr_addr), 41);
    chk("set_e2_busy", int'(busy), 0);
    tick();
    chk("set_done", int'(done_pulse), 1);
    chk("set_e3_wr", int'(wr_en), 0);

    // SET held off by closed window
    vblank = 0;
    w0 = n_wr;
    expect_run(600, 1, 2);
    send(0, 600, 0, 2);
    b = 0;
    repeat (100) begin tick(); b += int'(busy); end
    chk("hold_busy", b, 100);
    chk("hold_no_wr", n_wr - w0, 0);
    vblank = 1;
    wait_done("hold_done", 20);
    chk("hold_one_wr", n_wr - w0, 1);

    // FILL interrupted by blanking close after 10 cells
    w0 = n_wr; d0 = n_done;
    expect_run(1160, 40, 3);
    send(1, 1160, 40, 3);
    c = 0; k = 0;
    while (c < 10 && k < 100) begin tick(); c += int'(wr_en); k++; end
    vblank = 0;
    chk("fill_first10", c, 10);
    g = 0;
    repeat (50) begin tick(); g += int'(wr_en); end
    chk("fill_gap", g, 0);
    vblank = 1;
    wait_done("fill_done", 100);
    chk("fill_total", n_wr - w0, 40);
    chk("fill_one_done", n_done - d0, 1);

    // FIFO fill: one command in the FSM, four queued, sixth refused
    tick();
    vblank = 0;
    w0 = n_wr; d0 = n_done;
    for (int i = 0; i < 6; i++) begin
      cmd_op = 0; cmd_addr = 11'(10 * (i + 1)); cmd_data = 5'(i + 1); cmd_len = 0;
      cmd_valid = 1;
      if (i < 5) begin
        chk("q_ready", int'(cmd_ready), 1);
        expect_run(10 * (i + 1), 1, i + 1);
        tick();
      end else begin
        chk("q_full_ready", int'(cmd_ready), 0);
        chk("q_full_count", int'(fifo_count), 4);
      end
    end
    cmd_valid = 0;
    tick();
    vblank = 1;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    repeat (2) tick();
    chk("q_writes", n_wr - w0, 5);
    chk("q_dones", n_done - d0, 5);

    // illegal commands, then a legal FILL ending exactly at the last cell
    w0 = n_wr; e0 = n_err;
    send(0, 1200, 0, 1);
    chk("err_set", int'(err_pulse), 1);
    chk("err_set_count", int'(fifo_count), 0);
    send(1, 1190, 20, 1);
    chk("err_fill_over", int'(err_pulse), 1);
    send(1, 1100, 0, 1);
    chk("err_fill_zero", int'(err_pulse), 1);
    chk("err_count", int'(fifo_count), 0);
    repeat (4) tick();
    chk("err_total", n_err - e0, 3);
    chk("err_no_wr", n_wr - w0, 0);
    chk("err_idle", int'(busy), 0);
    expect_run(1190, 10, 7);
    send(1, 1190, 10, 7);
    chk("edge_legal_no_err", int'(err_pulse), 0);
    wait_done("edge_done", 40);
    chk("edge_writes", n_wr - w0, 10);

    // reset during a 40-cell FILL
    tick();
    w0 = n_wr;
    expect_run(0, 5, 6);
    send(1, 0, 40, 6);
    c = 0; k = 0;
    while (c < 5 && k < 100) begin tick(); c += int'(wr_en); k++; end
    rst_n = 0;
    tick();
    chk("mid_rst_wr", int'(wr_en), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst_n = 1;
    repeat (5) tick();
    chk("mid_rst_writes", n_wr - w0, 5);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
